// File: rtl/alu_regfile_ctrl_pkg.sv
// Shared definitions for the ALU register-file controller: opcode map, FSM states, defaults.
package alu_regfile_ctrl_pkg;

  localparam int WIDTH_DEF = 9;
  localparam int NREG_DEF  = 4;
  localparam int NRD       = 3;  // read ports: operand A, operand B, debug

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_DECB  = 4'd2,
    OP_MUL   = 4'd3,
    OP_LAND  = 4'd4,
    OP_LOR   = 4'd5,
    OP_LNOT  = 4'd6,
    OP_NOT   = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_XOR   = 4'd10,
    OP_SHL   = 4'd11,
    OP_SHR   = 4'd12,
    OP_INC   = 4'd13,
    OP_DEC   = 4'd14,
    OP_PASSB = 4'd15
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register array: one synchronous write port, NRD combinational read ports.
module alu_regfile
  import alu_regfile_ctrl_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NREG  = NREG_DEF,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [NRD-1:0][AW-1:0]    raddr,
  output logic [NRD-1:0][WIDTH-1:0] rdata
);

  logic [NREG-1:0][WIDTH-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign rdata[g] = regs_q[raddr[g]];
  end

endmodule

// File: rtl/alu_regfile_ctrl.sv
// Two-state controller: loads write in IDLE, ALU ops latch operands then write back from EXEC.
module alu_regfile_ctrl
  import alu_regfile_ctrl_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NREG  = NREG_DEF,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             instr_ld,
  input  logic [3:0]       instr_op,
  input  logic [AW-1:0]    instr_rd,
  input  logic [AW-1:0]    instr_ra,
  input  logic [AW-1:0]    instr_rb,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_z,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  alu_op_e             alu_sel_q, alu_sel_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [WIDTH-1:0]    res_data_q, res_data_d;
  logic                res_valid_q, res_valid_d;

  logic                we;
  logic [AW-1:0]       waddr;
  logic [WIDTH-1:0]    wdata;
  logic [NRD-1:0][AW-1:0]    raddr;
  logic [NRD-1:0][WIDTH-1:0] rdata;

  assign raddr = {dbg_addr, instr_rb, instr_ra};

  alu_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rd_d        = rd_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    we          = 1'b0;
    waddr       = instr_rd;
    wdata       = instr_imm;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (instr_ld) begin
            we          = 1'b1;
            res_data_d  = instr_imm;
            res_valid_d = 1'b1;
          end else begin
            alu_a_d   = rdata[0];
            alu_b_d   = rdata[1];
            alu_sel_d = alu_op_e'(instr_op);
            rd_d      = instr_rd;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        // destination comes from the latched rd, not the live instruction bus
        we          = 1'b1;
        waddr       = rd_q;
        wdata       = alu_z;
        res_data_d  = alu_z;
        res_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= OP_ADD;
      rd_q        <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rd_q        <= rd_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_zero    = (res_data_q == '0);
  assign dbg_data    = rdata[2];

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Bench for alu_regfile_ctrl: behavioural ALU, register model, directed table, hand sequences, random ops.
module tb_alu_regfile_ctrl;

  logic       clk, rst_n;
  logic       instr_valid, instr_ready, instr_ld;
  logic [3:0] instr_op;
  logic [1:0] instr_rd, instr_ra, instr_rb, dbg_addr;
  logic [8:0] instr_imm, alu_a, alu_b, alu_z, res_data, dbg_data;
  logic [3:0] alu_sel;
  logic       res_valid, res_zero;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [8:0] mdl [4];

  alu_regfile_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_ld(instr_ld),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_imm(instr_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_z(alu_z), .res_valid(res_valid), .res_data(res_data), .res_zero(res_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return b - 9'd1;
      4'd3:    return a * b;
      4'd4:    return {8'd0, (a != 0) && (b != 0)};
      4'd5:    return {8'd0, (a != 0) || (b != 0)};
      4'd6:    return {8'd0, a == 0};
      4'd7:    return ~a;
      4'd8:    return a & b;
      4'd9:    return a | b;
      4'd10:   return a ^ b;
      4'd11:   return a << 1;
      4'd12:   return a >> 1;
      4'd13:   return a + 9'd1;
      4'd14:   return a - 9'd1;
      default: return b;
    endcase
  endfunction

  assign alu_z = alu_fn(alu_sel, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dbg(input logic [1:0] a, input logic [8:0] exp);
    dbg_addr = a;
    #1;
    chk("dbg_data", dbg_data, exp);
  endtask

  // Issue one instruction at the current (ready) cycle and check its result.
  task automatic run(input logic ld, input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                     input logic [1:0] rb, input logic [8:0] imm, input logic [8:0] exp);
    logic [8:0] ea, eb;
    ea = mdl[ra];
    eb = mdl[rb];
    chk("ready_before", instr_ready, 1);
    instr_valid = 1'b1; instr_ld = ld; instr_op = op;
    instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
    step();
    if (ld) begin
      chk("ld_res_valid", res_valid, 1);
      chk("ld_res_data", res_data, exp);
      chk("ld_res_zero", res_zero, exp == 0);
      chk("ld_ready", instr_ready, 1);
    end else begin
      chk("exec_ready_low", instr_ready, 0);
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_sel", alu_sel, op);
      chk("exec_res_valid_low", res_valid, 0);
      instr_valid = 1'b0;
      step();
      chk("op_res_valid", res_valid, 1);
      chk("op_res_data", res_data, exp);
      chk("op_res_zero", res_zero, exp == 0);
      chk("op_ready_back", instr_ready, 1);
    end
    instr_valid = 1'b0;
    mdl[rd] = exp;
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] op;
    logic [1:0] rd, ra, rb;
    logic [8:0] imm;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1'b1, 4'd0,  2'd1, 2'd0, 2'd0, 9'd5,   9'd5};   // load r1=5
    tbl[1] = '{1'b1, 4'd0,  2'd2, 2'd0, 2'd0, 9'd3,   9'd3};   // load r2=3
    tbl[2] = '{1'b0, 4'd0,  2'd0, 2'd1, 2'd2, 9'd0,   9'd8};   // ADD r0=r1+r2
    tbl[3] = '{1'b0, 4'd1,  2'd3, 2'd1, 2'd2, 9'd0,   9'd2};   // SUB r3=r1-r2
    tbl[4] = '{1'b0, 4'd0,  2'd3, 2'd3, 2'd3, 9'd0,   9'd4};   // ADD r3=r3+r3
    tbl[5] = '{1'b1, 4'd0,  2'd1, 2'd0, 2'd0, 9'd511, 9'd511}; // load r1=511
    tbl[6] = '{1'b0, 4'd13, 2'd1, 2'd1, 2'd1, 9'd0,   9'd0};   // INC r1 wraps

    rst_n = 1'b0; instr_valid = 1'b0; instr_ld = 1'b0; instr_op = '0;
    instr_rd = '0; instr_ra = '0; instr_rb = '0; instr_imm = '0; dbg_addr = '0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;

    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    for (int i = 0; i < 4; i++) chk_dbg(2'(i), 9'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed table; entries 0 and 1 are back-to-back loads
    for (int i = 0; i < 7; i++) begin
      run(tbl[i].ld, tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].imm, tbl[i].exp);
      if (i == 1) begin
        chk_dbg(2'd1, 9'd5);
        chk_dbg(2'd2, 9'd3);
      end
    end
    chk_dbg(2'd0, 9'd8);
    chk_dbg(2'd1, 9'd0);
    chk_dbg(2'd3, 9'd4);
    step();
    chk("idle_res_valid", res_valid, 0);

    // valid held through EXEC with changing fields: only the IDLE-edge op counts
    run(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 9'd5, 9'd5);
    instr_valid = 1'b1; instr_ld = 1'b0; instr_op = 4'd0;
    instr_rd = 2'd0; instr_ra = 2'd1; instr_rb = 2'd3;
    step();
    instr_ld = 1'b1; instr_rd = 2'd2; instr_imm = 9'd77; instr_op = 4'd7;
    step();
    chk("hold_res_valid", res_valid, 1);
    chk("hold_res_data", res_data, 9'd9);
    mdl[0] = 9'd9;
    instr_ld = 1'b0; instr_op = 4'd10; instr_rd = 2'd3; instr_ra = 2'd0; instr_rb = 2'd1;
    step();
    chk("hold_accept_sel", alu_sel, 10);
    chk("hold_accept_ready", instr_ready, 0);
    instr_valid = 1'b0;
    step();
    chk("hold_xor_data", res_data, 9'd9 ^ 9'd5);
    mdl[3] = 9'd9 ^ 9'd5;
    chk_dbg(2'd2, 9'd3);
    chk_dbg(2'd0, 9'd9);

    // reset while in EXEC abandons the op
    instr_valid = 1'b1; instr_ld = 1'b0; instr_op = 4'd15; instr_rd = 2'd2; instr_rb = 2'd0;
    step();
    chk("pre_rst_exec", instr_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", instr_ready, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_alu_sel", alu_sel, 0);
    for (int i = 0; i < 4; i++) chk_dbg(2'(i), 9'd0);
    instr_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    step();
    chk("post_rst_res_valid", res_valid, 0);
    chk("post_rst_ready", instr_ready, 1);
    chk_dbg(2'd2, 9'd0);

    // random instruction stream against the register model
    for (int n = 0; n < 200; n++) begin
      logic       ld;
      logic [3:0] op;
      logic [1:0] rd, ra, rb, da;
      logic [8:0] imm, ez;
      ld  = ($urandom_range(0, 2) == 0);
      op  = 4'($urandom_range(0, 15));
      rd  = 2'($urandom_range(0, 3));
      ra  = 2'($urandom_range(0, 3));
      rb  = 2'($urandom_range(0, 3));
      imm = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
      ez  = ld ? imm : alu_fn(op, mdl[ra], mdl[rb]);
      run(ld, op, rd, ra, rb, imm, ez);
      da = 2'($urandom_range(0, 3));
      chk_dbg(da, mdl[da]);
      if ($urandom_range(0, 4) == 0) begin
        step();
        chk("rnd_gap_res_valid", res_valid, 0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
